// File: rtl/dmem_byte_ctrl_pkg.sv
// rtl/dmem_byte_ctrl_pkg.sv - size encodings, response metadata and lane helpers
package dmem_byte_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_DOUBLE = 2'b11
    } size_t;

    // Offset is kept 3 bits wide so one struct serves both 32- and 64-bit words.
    typedef struct packed {
        logic       valid;
        logic       err;
        logic       load;
        size_t      size;
        logic       uns;
        logic [2:0] off;
    } resp_meta_t;

    function automatic logic [7:0] lane_mask(input size_t size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            SZ_BYTE: base = 8'h01;
            SZ_HALF: base = 8'h03;
            SZ_WORD: base = 8'h0f;
            default: base = 8'hff;
        endcase
        return base << off;
    endfunction

    function automatic logic misaligned(input size_t size, input logic [2:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return |off[1:0];
            default: return |off;
        endcase
    endfunction

    function automatic logic [63:0] extend_load(input logic [63:0] v, input size_t size,
                                                input logic uns);
        case (size)
            SZ_BYTE: return {{56{~uns & v[7]}}, v[7:0]};
            SZ_HALF: return {{48{~uns & v[15]}}, v[15:0]};
            SZ_WORD: return {{32{~uns & v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// rtl/dmem_lane.sv - single-port byte RAM for one lane, registered read
module dmem_lane #(
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_byte_ctrl.sv
// rtl/dmem_byte_ctrl.sv - byte-addressable data memory with aligned sub-word access
module dmem_byte_ctrl
    import dmem_byte_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUS_WIDTH    = 24,
    parameter int READ_LATENCY = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        req,
    input  logic                                        we,
    input  logic [1:0]                                  size,
    input  logic                                        uns,
    input  logic [BUS_WIDTH+$clog2(DATA_WIDTH/8)-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]                       wdata,
    output logic                                        resp_valid,
    output logic                                        resp_err,
    output logic [DATA_WIDTH-1:0]                       rdata
);

    localparam int NLANES = DATA_WIDTH / 8;
    localparam int OFFW   = $clog2(NLANES);

    size_t                 req_size;
    logic [2:0]            off;
    logic [BUS_WIDTH-1:0]  word_addr;
    logic                  illegal;
    logic                  accept;
    logic [7:0]            mask_full;
    logic [NLANES-1:0]     lane_we;
    logic [DATA_WIDTH-1:0] wdata_aligned;
    logic [DATA_WIDTH-1:0] lane_q;

    assign req_size      = size_t'(size);
    assign off           = 3'(addr[OFFW-1:0]);
    assign word_addr     = addr[BUS_WIDTH+OFFW-1:OFFW];
    assign illegal       = misaligned(req_size, off) || (req_size == SZ_DOUBLE && DATA_WIDTH < 64);
    assign accept        = req && !rst;
    assign mask_full     = lane_mask(req_size, off);
    assign lane_we       = (accept && we && !illegal) ? mask_full[NLANES-1:0] : '0;
    assign wdata_aligned = wdata << {off, 3'b000};

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        dmem_lane #(.AW(BUS_WIDTH)) u_lane (
            .clk   (clk),
            .we    (lane_we[i]),
            .re    (accept && !we),
            .addr  (word_addr),
            .wdata (wdata_aligned[8*i +: 8]),
            .rdata (lane_q[8*i +: 8])
        );
    end

    resp_meta_t meta_in;
    resp_meta_t pipe [READ_LATENCY];

    always_comb begin
        meta_in       = '0;
        meta_in.valid = accept;
        meta_in.err   = illegal;
        meta_in.load  = !we;
        meta_in.size  = req_size;
        meta_in.uns   = uns;
        meta_in.off   = off;
    end

    // Only the control pipeline is reset; in-flight requests vanish with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= meta_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Lane RAM output is the first data stage; extra stages just delay raw words.
    logic [DATA_WIDTH-1:0] raw;

    if (READ_LATENCY > 1) begin : g_dpipe
        logic [DATA_WIDTH-1:0] dstage [1:READ_LATENCY-1];
        always_ff @(posedge clk) begin
            dstage[1] <= lane_q;
            for (int i = 2; i < READ_LATENCY; i++) begin
                dstage[i] <= dstage[i-1];
            end
        end
        assign raw = dstage[READ_LATENCY-1];
    end else begin : g_nodpipe
        assign raw = lane_q;
    end

    resp_meta_t            meta_out;
    logic [DATA_WIDTH-1:0] shifted;
    logic [63:0]           ext64;
    logic                  unused_bits;

    always_comb begin
        meta_out   = pipe[READ_LATENCY-1];
        shifted    = raw >> {meta_out.off, 3'b000};
        ext64      = extend_load(64'(shifted), meta_out.size, meta_out.uns);
        resp_valid = meta_out.valid;
        resp_err   = meta_out.valid && meta_out.err;
        rdata      = '0;
        if (meta_out.valid && meta_out.load && !meta_out.err) begin
            rdata = ext64[DATA_WIDTH-1:0];
        end
    end

    assign unused_bits = ^{mask_full, ext64};

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// tb/tb_dmem_byte_ctrl.sv - randomized and directed bench for dmem_byte_ctrl
module tb_dmem_byte_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [31:0] wdata = 32'h0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] rdata;

    int checks = 0;
    int fails = 0;
    int tick = 0;

    bit [7:0]  mem_model [256];
    bit        ev [4096];
    bit        ee [4096];
    bit [31:0] ed [4096];

    typedef struct packed {
        bit        we;
        bit [1:0]  sz;
        bit        u;
        bit [7:0]  a;
        bit [31:0] d;
        bit        chk;
        bit        err;
        bit [31:0] lit;
    } op_t;

    dmem_byte_ctrl #(
        .DATA_WIDTH   (32),
        .BUS_WIDTH    (6),
        .READ_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .size       (size),
        .uns        (uns),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .rdata      (rdata)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs and records the response the memory owes for it.
    task automatic cycle_io(input bit r_rst, input bit r_req, input bit r_we, input bit [1:0] r_size,
                            input bit r_uns, input bit [7:0] r_addr, input bit [31:0] r_wdata);
        int n;
        bit bad;
        longint unsigned v;
        @(posedge clk);
        #1;
        tick++;
        rst = r_rst; req = r_req; we = r_we; size = r_size;
        uns = r_uns; addr = r_addr; wdata = r_wdata;
        if (r_rst) begin
            for (int t = tick; t < tick + LAT + 2; t++) begin
                ev[t] = 1'b0; ee[t] = 1'b0; ed[t] = '0;
            end
        end else if (r_req) begin
            n = 1 << r_size;
            bad = (r_size == 2'b11) || (int'(r_addr) % n != 0);
            v = 0;
            if (!bad) begin
                for (int i = 0; i < n; i++) begin
                    if (r_we) mem_model[8'(int'(r_addr) + i)] = r_wdata[8*i +: 8];
                    else v = v | (64'(mem_model[8'(int'(r_addr) + i)]) << (8 * i));
                end
                if (!r_we && !r_uns && v[8*n-1]) v = v - (64'd1 << (8 * n));
            end
            ev[tick+LAT] = 1'b1;
            ee[tick+LAT] = bad;
            ed[tick+LAT] = (bad || r_we) ? 32'h0 : v[31:0];
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            cycle_io(1, 1, 1, 2'b10, 0, 8'h00, 32'hffffffff);
            checks++;
            if (resp_valid !== 1'b0 || resp_err !== 1'b0 || rdata !== 32'h0) begin
                fails++;
                $display("FAIL reset_outputs tick %0d: got v=%b e=%b d=%h, want 0/0/00000000",
                         tick, resp_valid, resp_err, rdata);
            end
        end
        cycle_io(0, 0, 0, 2'b00, 0, 8'h00, 32'h0);
        checks++;
        if (resp_valid !== ev[tick] || resp_err !== ee[tick] || rdata !== ed[tick]) begin
            fails++;
            $display("FAIL reset_release tick %0d: got v=%b e=%b d=%h, want %b/%b/%h",
                     tick, resp_valid, resp_err, rdata, ev[tick], ee[tick], ed[tick]);
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 64 + LAT; k++) begin
            if (k < 64) cycle_io(0, 1, 1, 2'b10, 0, 8'(k * 4), $urandom);
            else cycle_io(0, 0, 0, 2'b00, 0, 8'h00, 32'h0);
            checks++;
            if (resp_valid !== ev[tick] || resp_err !== ee[tick] || rdata !== ed[tick]) begin
                fails++;
                $display("FAIL fill tick %0d: got v=%b e=%b d=%h, want %b/%b/%h",
                         tick, resp_valid, resp_err, rdata, ev[tick], ee[tick], ed[tick]);
            end
        end
    endtask

    task automatic test_directed();
        op_t ops [15];
        int  due_q [$];
        bit [32:0] lit_q [$];
        ops = '{
            '{1, 2'b10, 0, 8'h00, 32'habcdfe01, 0, 0, 32'h0},
            '{0, 2'b10, 0, 8'h00, 32'h0,        1, 0, 32'habcdfe01},
            '{1, 2'b10, 0, 8'h04, 32'hffffaaaa, 0, 0, 32'h0},
            '{1, 2'b00, 0, 8'h05, 32'h0000007f, 0, 0, 32'h0},
            '{0, 2'b10, 0, 8'h04, 32'h0,        1, 0, 32'hffff7faa},
            '{1, 2'b00, 0, 8'h06, 32'h00000080, 0, 0, 32'h0},
            '{0, 2'b00, 0, 8'h06, 32'h0,        1, 0, 32'hffffff80},
            '{0, 2'b00, 1, 8'h06, 32'h0,        1, 0, 32'h00000080},
            '{0, 2'b01, 0, 8'h03, 32'h0,        1, 1, 32'h0},
            '{1, 2'b10, 0, 8'h02, 32'h12345678, 1, 1, 32'h0},
            '{0, 2'b10, 0, 8'h00, 32'h0,        1, 0, 32'habcdfe01},
            '{1, 2'b10, 0, 8'h08, 32'h11223344, 0, 0, 32'h0},
            '{0, 2'b10, 0, 8'h00, 32'h0,        1, 0, 32'habcdfe01},
            '{0, 2'b10, 0, 8'h04, 32'h0,        1, 0, 32'hff807faa},
            '{0, 2'b10, 0, 8'h08, 32'h0,        1, 0, 32'h11223344}
        };
        for (int k = 0; k < 15 + LAT + 1; k++) begin
            if (k < 15) begin
                cycle_io(0, 1, ops[k].we, ops[k].sz, ops[k].u, ops[k].a, ops[k].d);
                if (ops[k].chk) begin
                    due_q.push_back(tick + LAT);
                    lit_q.push_back({ops[k].err, ops[k].lit});
                end
            end else begin
                cycle_io(0, 0, 0, 2'b00, 0, 8'h00, 32'h0);
            end
            checks++;
            if (resp_valid !== ev[tick] || resp_err !== ee[tick] || rdata !== ed[tick]) begin
                fails++;
                $display("FAIL directed_model tick %0d: got v=%b e=%b d=%h, want %b/%b/%h",
                         tick, resp_valid, resp_err, rdata, ev[tick], ee[tick], ed[tick]);
            end
            if (due_q.size() > 0 && due_q[0] == tick) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_err !== lit_q[0][32] || rdata !== lit_q[0][31:0]) begin
                    fails++;
                    $display("FAIL directed_value tick %0d: got v=%b e=%b d=%h, want 1/%b/%h",
                             tick, resp_valid, resp_err, rdata, lit_q[0][32], lit_q[0][31:0]);
                end
                void'(due_q.pop_front());
                void'(lit_q.pop_front());
            end
        end
    endtask

    task automatic test_reset_midflight();
        int lw_tick;
        cycle_io(0, 1, 0, 2'b10, 0, 8'h00, 32'h0);
        cycle_io(1, 1, 1, 2'b10, 0, 8'h20, 32'hdeadbeef);
        for (int k = 0; k < LAT + 1; k++) begin
            if (k > 0) cycle_io(0, 0, 0, 2'b00, 0, 8'h00, 32'h0);
            checks++;
            if (resp_valid !== 1'b0 || resp_err !== 1'b0 || rdata !== 32'h0) begin
                fails++;
                $display("FAIL midflight_drop tick %0d: got v=%b e=%b d=%h, want 0/0/00000000",
                         tick, resp_valid, resp_err, rdata);
            end
        end
        cycle_io(0, 1, 0, 2'b10, 0, 8'h00, 32'h0);
        lw_tick = tick;
        cycle_io(0, 1, 0, 2'b10, 0, 8'h20, 32'h0);
        for (int k = 0; k < LAT + 1; k++) begin
            if (k > 0) cycle_io(0, 0, 0, 2'b00, 0, 8'h00, 32'h0);
            checks++;
            if (resp_valid !== ev[tick] || resp_err !== ee[tick] || rdata !== ed[tick]) begin
                fails++;
                $display("FAIL midflight_model tick %0d: got v=%b e=%b d=%h, want %b/%b/%h",
                         tick, resp_valid, resp_err, rdata, ev[tick], ee[tick], ed[tick]);
            end
            if (tick == lw_tick + LAT) begin
                checks++;
                if (resp_valid !== 1'b1 || rdata !== 32'habcdfe01) begin
                    fails++;
                    $display("FAIL midflight_reload tick %0d: got v=%b d=%h, want 1/abcdfe01",
                             tick, resp_valid, rdata);
                end
            end
        end
    endtask

    task automatic test_random();
        bit        r_rst, r_req, r_we, r_uns;
        bit [1:0]  r_sz;
        bit [7:0]  r_a;
        for (int k = 0; k < 600 + LAT + 1; k++) begin
            if (k < 600) begin
                r_rst = ($urandom_range(0, 99) == 0);
                r_req = ($urandom_range(0, 3) != 0);
                r_we  = $urandom_range(0, 1) == 1;
                r_uns = $urandom_range(0, 1) == 1;
                r_sz  = 2'($urandom_range(0, 3));
                r_a   = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 4) != 0) r_a = r_a & ~8'((1 << r_sz) - 1);
                cycle_io(r_rst, r_req, r_we, r_sz, r_uns, r_a, $urandom);
            end else begin
                cycle_io(0, 0, 0, 2'b00, 0, 8'h00, 32'h0);
            end
            checks++;
            if (resp_valid !== ev[tick] || resp_err !== ee[tick] || rdata !== ed[tick]) begin
                fails++;
                $display("FAIL random tick %0d: got v=%b e=%b d=%h, want %b/%b/%h",
                         tick, resp_valid, resp_err, rdata, ev[tick], ee[tick], ed[tick]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
